lc3_pipe_reg: RTL and testbench
===============================

// Module: lc3_pipe_reg
// PURPOSE
//   Parametrised pipeline stage register for the pipelined LC-3 datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Replaces the plain load-enabled register with a valid/ready handshaked stage.
//   Has an optional skid entry, so the upstream ready is registered and breaks the stall path.
//   Supports synchronous flush for branch squash and bubble insertion, and emits a NOP value when empty.
// PARAMETERS
//   WIDTH     16       payload width in bits (instruction, PC, or packed control bundle)
//   RESET_VAL 16'h0000 value driven on out_data when no valid entry is held; sized to WIDTH (0x0000 = LC-3 BR-never NOP)
//   SKID      1        1: two-entry stage (main + skid), in_ready registered; 0: single entry, in_ready combinational
// PORTS
//   clk       in   1      rising-edge clock, sole clock domain
//   rst       in   1      synchronous, active-high reset
//   in_valid  in   1      upstream presents in_data
//   in_ready  out  1      stage can accept; transfer occurs when in_valid & in_ready at posedge clk
//   in_data   in   WIDTH  upstream payload
//   flush     in   1      synchronous squash of all held entries
//   out_valid out  1      main entry holds valid payload
//   out_ready in   1      downstream accepts; transfer occurs when out_valid & out_ready at posedge clk
//   out_data  out  WIDTH  main entry payload; equals RESET_VAL whenever out_valid=0
//   occupancy out  2      entries held: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//   Reset (rst=1 at posedge): out_valid=0, out_data=RESET_VAL, occupancy=0; in_ready=1 (SKID=1) from the following cycle.
//     rst overrides flush and all transfers.
//   States (SKID=1): EMPTY(occ 0) / ONE(main valid) / FULL(main+skid valid). in_ready = (state!=FULL), registered.
//     In = in_valid&in_ready; Out = out_valid&out_ready.
//     EMPTY: In -> ONE, main<=in_data. No In -> stay.
//     ONE: In&Out -> ONE, main<=in_data. In&!Out -> FULL, skid<=in_data.
//       !In&Out -> EMPTY, main<=RESET_VAL. Neither -> hold.
//     FULL: in_ready=0, so no In. Out -> ONE, main<=skid, skid<=RESET_VAL. !Out -> hold.
//   SKID=0: single entry. in_ready = !out_valid | out_ready (combinational).
//     Transitions as EMPTY/ONE above; FULL unreachable.
//   Latency: in_data visible on out_data 1 cycle after the accepting edge. Order strictly FIFO; no drop, no duplicate.
//   Data is held stable while out_valid=1 and out_ready=0.
//   flush=1 at posedge: next state EMPTY, main and skid <= RESET_VAL.
//     A same-cycle upstream transfer is discarded, but counts as accepted (upstream must not retry).
//     A same-cycle downstream transfer still completes.
//   Upstream must hold in_data/in_valid until accepted; the stage does not check this.
//   X on in_data with in_valid=0 must never reach out_data.
// TESTING
//   1 Reset: rst=1 for 2 cycles with in_valid=1, in_data=16'h1234 -> out_valid=0, out_data=16'h0000, occupancy=0 after reset; in_ready=1.
//   2 Streaming: out_ready=1, push 16'h1021,16'h5260,16'h0FF9 on consecutive cycles
//     -> same words on out_data 1 cycle later, back-to-back, in_ready stays 1.
//   3 Skid: hold out_ready=0, push A=16'hE002, B=16'h6042
//     -> occupancy=2, in_ready=0 next cycle, out_data=A stable.
//     Release out_ready -> A then B, then out_valid=0 and out_data=16'h0000.
//   4 Flush: stage FULL, assert flush with in_valid=1, in_data=16'hC1C0
//     -> next cycle occupancy=0, out_valid=0, out_data=RESET_VAL, 16'hC1C0 never appears.
//   5 Mid-operation reset: rst=1 while FULL with out_ready=1 -> EMPTY next cycle, no further output transfers.
//   6 SKID=0, WIDTH=32, RESET_VAL=32'hDEAD_BEEF: out_ready=0 with entry held -> in_ready=0 combinationally.
//     out_ready=1 in same cycle -> in_ready=1 and replace-in-place. Empty -> out_data=32'hDEAD_BEEF.

Source files
------------

// File: rtl/lc3_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module : lc3_pipe_reg_if
// Brief  : Handshake bundle for an LC-3 pipeline stage register.
// Rev    : 1.0  initial release
// ============================================================================
interface lc3_pipe_reg_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/lc3_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module : lc3_pipe_reg
// Brief  : Valid/ready pipeline stage with optional skid entry and flush.
// Rev    : 1.0  initial release
// ============================================================================
module lc3_pipe_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  wire          clk,
  input  wire          rst,
  lc3_pipe_reg_if.slave bus
);

  // Encoding chosen so the state value is the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_next_main;
  logic [WIDTH-1:0] w_next_skid;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_xfer   = bus.in_valid & w_in_ready;
  assign w_out_xfer  = w_out_valid & bus.out_ready;

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_next_state != S_FULL);
        end
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = ~w_out_valid | bus.out_ready;
    end
  endgenerate

  always_comb begin
    w_next_state = r_state;
    w_next_main  = r_main;
    w_next_skid  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_next_state = S_ONE;
          w_next_main  = bus.in_data;
        end
      end
      S_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_next_main = bus.in_data;
        end else if (w_in_xfer) begin
          w_next_state = S_FULL;
          w_next_skid  = bus.in_data;
        end else if (w_out_xfer) begin
          w_next_state = S_EMPTY;
          w_next_main  = RESET_VAL;
        end
      end
      S_FULL: begin
        if (w_out_xfer) begin
          w_next_state = S_ONE;
          w_next_main  = r_skid;
          w_next_skid  = RESET_VAL;
        end
      end
      default: begin
        w_next_state = S_EMPTY;
        w_next_main  = RESET_VAL;
        w_next_skid  = RESET_VAL;
      end
    endcase
    // Squash wins over any accepted word; the downstream handoff already happened.
    if (bus.flush) begin
      w_next_state = S_EMPTY;
      w_next_main  = RESET_VAL;
      w_next_skid  = RESET_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_next_state;
      r_main  <= w_next_main;
      r_skid  <= w_next_skid;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_main : RESET_VAL;
  assign bus.occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lc3_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_lc3_pipe_reg
// Brief  : Directed vector bench for lc3_pipe_reg (skid and no-skid builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_lc3_pipe_reg;

  logic clk;
  logic rst;
  logic rst2;

  lc3_pipe_reg_if #(.WIDTH(16)) b1 ();
  lc3_pipe_reg_if #(.WIDTH(32)) b2 ();

  lc3_pipe_reg #(
    .WIDTH     (16),
    .RESET_VAL (16'h0000),
    .SKID      (1'b1)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  lc3_pipe_reg #(
    .WIDTH     (32),
    .RESET_VAL (32'hDEAD_BEEF),
    .SKID      (1'b0)
  ) u_noskid (
    .clk (clk),
    .rst (rst2),
    .bus (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        iv;
    logic [15:0] d;
    logic        fl;
    logic        ordy;
    logic        ov;
    logic [15:0] od;
    logic        ir;
    logic [1:0]  occ;
  } vec_t;

  vec_t vq[$];
  int   tests;
  int   fails;

  task automatic addv(input string name, input logic r, input logic iv,
                      input logic [15:0] d, input logic fl, input logic ordy,
                      input logic ov, input logic [15:0] od, input logic ir,
                      input logic [1:0] occ);
    vec_t t;
    t.name = name; t.rst = r; t.iv = iv; t.d = d; t.fl = fl; t.ordy = ordy;
    t.ov = ov; t.od = od; t.ir = ir; t.occ = occ;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    rst2  = 1'b1;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.flush = 1'b0; b2.out_ready = 1'b0;

    //    name          rst iv d         fl ordy | ov od        ir occ
    addv("reset0",      1, 1, 16'h1234, 0, 0,    0, 16'h0000, 1, 2'd0);
    addv("reset1",      1, 1, 16'h1234, 0, 0,    0, 16'h0000, 1, 2'd0);
    addv("stream0",     0, 1, 16'h1021, 0, 1,    1, 16'h1021, 1, 2'd1);
    addv("stream1",     0, 1, 16'h5260, 0, 1,    1, 16'h5260, 1, 2'd1);
    addv("stream2",     0, 1, 16'h0FF9, 0, 1,    1, 16'h0FF9, 1, 2'd1);
    addv("drain_x",     0, 0, 16'hxxxx, 0, 1,    0, 16'h0000, 1, 2'd0);
    addv("skid_a",      0, 1, 16'hE002, 0, 0,    1, 16'hE002, 1, 2'd1);
    addv("skid_b",      0, 1, 16'h6042, 0, 0,    1, 16'hE002, 0, 2'd2);
    addv("skid_hold",   0, 1, 16'h6042, 0, 0,    1, 16'hE002, 0, 2'd2);
    addv("skid_outa",   0, 0, 16'hxxxx, 0, 1,    1, 16'h6042, 1, 2'd1);
    addv("skid_outb",   0, 0, 16'hxxxx, 0, 1,    0, 16'h0000, 1, 2'd0);
    addv("fill1",       0, 1, 16'h3001, 0, 0,    1, 16'h3001, 1, 2'd1);
    addv("fill2",       0, 1, 16'h3002, 0, 0,    1, 16'h3001, 0, 2'd2);
    addv("flush_full",  0, 1, 16'hC1C0, 1, 0,    0, 16'h0000, 1, 2'd0);
    addv("one_again",   0, 1, 16'h4444, 0, 0,    1, 16'h4444, 1, 2'd1);
    addv("flush_inout", 0, 1, 16'hC1C0, 1, 1,    0, 16'h0000, 1, 2'd0);
    addv("post_flush",  0, 0, 16'hxxxx, 0, 1,    0, 16'h0000, 1, 2'd0);
    addv("mfill1",      0, 1, 16'h5001, 0, 0,    1, 16'h5001, 1, 2'd1);
    addv("mfill2",      0, 1, 16'h5002, 0, 0,    1, 16'h5001, 0, 2'd2);
    addv("mid_reset",   1, 0, 16'hxxxx, 0, 1,    0, 16'h0000, 1, 2'd0);
    addv("after_reset", 0, 0, 16'hxxxx, 0, 1,    0, 16'h0000, 1, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      rst          = vq[i].rst;
      b1.in_valid  = vq[i].iv;
      b1.in_data   = vq[i].d;
      b1.flush     = vq[i].fl;
      b1.out_ready = vq[i].ordy;
      @(posedge clk);
      #1;
      chk({vq[i].name, ".out_valid"}, {31'd0, b1.out_valid}, {31'd0, vq[i].ov});
      chk({vq[i].name, ".out_data"},  {16'd0, b1.out_data},  {16'd0, vq[i].od});
      chk({vq[i].name, ".in_ready"},  {31'd0, b1.in_ready},  {31'd0, vq[i].ir});
      chk({vq[i].name, ".occupancy"}, {30'd0, b1.occupancy}, {30'd0, vq[i].occ});
    end
    b1.in_valid = 1'b0; b1.flush = 1'b0;

    // Single-entry build: combinational ready and replace-in-place.
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    chk("ns_reset.out_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("ns_reset.out_data",  b2.out_data, 32'hDEAD_BEEF);
    chk("ns_reset.occupancy", {30'd0, b2.occupancy}, 32'd0);
    chk("ns_reset.in_ready",  {31'd0, b2.in_ready}, 32'd1);

    b2.in_valid = 1'b1; b2.in_data = 32'h1111_1111; b2.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("ns_load.out_data",  b2.out_data, 32'h1111_1111);
    chk("ns_load.occupancy", {30'd0, b2.occupancy}, 32'd1);

    b2.in_data = 32'h2222_2222;
    #1;
    chk("ns_stall.in_ready", {31'd0, b2.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ns_stall.out_data", b2.out_data, 32'h1111_1111);

    b2.out_ready = 1'b1;
    #1;
    chk("ns_go.in_ready", {31'd0, b2.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("ns_replace.out_data",  b2.out_data, 32'h2222_2222);
    chk("ns_replace.occupancy", {30'd0, b2.occupancy}, 32'd1);

    b2.in_valid = 1'b0; b2.in_data = 'x;
    @(posedge clk); #1;
    chk("ns_empty.out_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("ns_empty.out_data",  b2.out_data, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
